// File: rtl/rs_encode_stream.sv
// ============================================================================
// rs_encode_stream : systematic RS(255,255-PARITY) stream encoder, GF(2^8)
// Rev 1.0
// ============================================================================
`default_nettype none

module rs_encode_stream #(
   parameter int         PARITY    = 16,
   parameter logic [8:0] PRIM_POLY = 9'h11D
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_sop,
   input  logic       in_eop,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_sop,
   output logic       out_eop,
   output logic       out_parity,
   output logic       out_err
);

   localparam logic [7:0] MAX_MSG = 8'(255 - PARITY);
   localparam logic [5:0] P_LAST  = 6'(PARITY - 1);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ PRIM_POLY[7:0]) : (aa << 1);
      end
      return p;
   endfunction

   // g(x) = prod (x + alpha^i), built up one root at a time
   function automatic logic [PARITY:0][7:0] gen_poly();
      logic [PARITY:0][7:0] g;
      logic [7:0]           root;
      g    = '0;
      g[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < PARITY; i++) begin
         for (int j = PARITY; j > 0; j--)
            g[j] = g[j-1] ^ gmul(g[j], root);
         g[0] = gmul(g[0], root);
         root = gmul(root, 8'h02);
      end
      return g;
   endfunction

   localparam logic [PARITY:0][7:0] GEN = gen_poly();

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t                 state;
   logic [PARITY-1:0][7:0] lfsr;
   logic [PARITY-1:0][7:0] base;
   logic [PARITY-1:0][7:0] fed;
   logic [7:0]             fb;
   logic [7:0]             count;
   logic [5:0]             pcnt;
   logic                   accept;

   assign accept = in_valid & in_ready;

   // A start-of-message symbol feeds a cleared register bank
   always_comb begin
      base   = in_sop ? '0 : lfsr;
      fb     = in_data ^ base[PARITY-1];
      fed    = '0;
      fed[0] = gmul(GEN[0], fb);
      for (int i = 1; i < PARITY; i++)
         fed[i] = base[i-1] ^ gmul(GEN[i], fb);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= S_IDLE;
         lfsr       <= '0;
         count      <= 8'd0;
         pcnt       <= 6'd0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= 8'h00;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         out_parity <= 1'b0;
         out_err    <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         out_data   <= 8'h00;
         out_sop    <= 1'b0;
         out_eop    <= 1'b0;
         out_parity <= 1'b0;
         out_err    <= 1'b0;
         case (state)
            S_IDLE, S_DATA: begin
               if (accept && (in_sop || state == S_DATA)) begin
                  lfsr      <= fed;
                  pcnt      <= 6'd0;
                  out_valid <= 1'b1;
                  out_data  <= in_data;
                  out_sop   <= in_sop;
                  if (in_sop) begin
                     count   <= 8'd1;
                     out_err <= (state == S_DATA);
                     if (in_eop) begin
                        state    <= S_PARITY;
                        in_ready <= 1'b0;
                     end else begin
                        state <= S_DATA;
                     end
                  end else begin
                     count <= count + 8'd1;
                     if (in_eop) begin
                        state    <= S_PARITY;
                        in_ready <= 1'b0;
                     end else if (count + 8'd1 == MAX_MSG) begin
                        state    <= S_PARITY;
                        in_ready <= 1'b0;
                        out_err  <= 1'b1;
                     end
                  end
               end
            end
            S_PARITY: begin
               out_valid  <= 1'b1;
               out_parity <= 1'b1;
               out_data   <= lfsr[PARITY-1];
               lfsr       <= lfsr << 8;
               pcnt       <= pcnt + 6'd1;
               if (pcnt == P_LAST) begin
                  out_eop  <= 1'b1;
                  state    <= S_IDLE;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= S_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rs_encode_stream.sv
// ============================================================================
// tb_rs_encode_stream : random-stimulus bench against a polynomial-division model
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rs_encode_stream;

   localparam int P = 16;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_sop = 1'b0;
   logic       in_eop = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;
   logic       out_parity;
   logic       out_err;

   rs_encode_stream #(.PARITY(P), .PRIM_POLY(9'h11D)) dut (
      .CLK(CLK), .RESET(RESET),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sop(in_sop), .in_eop(in_eop),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
      .out_eop(out_eop), .out_parity(out_parity), .out_err(out_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       err;
      logic       par;
      logic       eop;
      logic       sop;
      logic [7:0] d;
   } rec_t;

   rec_t       outq[$];
   rec_t       expq[$];
   int         cycq[$];
   rec_t       mon_r;
   int         cyc = 0;
   int         ready_low = 0;
   int         total = 0;
   int         bad = 0;
   logic [7:0] msg   [0:299];
   logic [7:0] par   [0:P-1];
   logic [7:0] gpoly [0:P];

   always @(negedge CLK) begin
      cyc++;
      if (!in_ready) ready_low++;
      if (out_valid) begin
         mon_r = {out_err, out_parity, out_eop, out_sop, out_data};
         outq.push_back(mon_r);
         cycq.push_back(cyc);
      end
   end

   // carry-less product followed by reduction modulo x^8+x^4+x^3+x^2+1
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = 16'h0;
      for (int k = 0; k < 8; k++) if (b[k]) prod = prod ^ (16'(a) << k);
      for (int k = 15; k >= 8; k--) if (prod[k]) prod = prod ^ (16'h11D << (k - 8));
      return prod[7:0];
   endfunction

   task automatic make_gen();
      logic [7:0] root;
      for (int j = 0; j <= P; j++) gpoly[j] = 8'h00;
      gpoly[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < P; i++) begin
         for (int j = P; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gm(gpoly[j], root);
         gpoly[0] = gm(gpoly[0], root);
         root = gm(root, 8'h02);
      end
   endtask

   // parity = remainder of m(x)*x^P divided by g(x), highest degree first
   task automatic model(input int len);
      logic [7:0] rem [0:299];
      logic [7:0] c;
      for (int i = 0; i < len + P; i++) rem[i] = (i < len) ? msg[i] : 8'h00;
      for (int i = 0; i < len; i++) begin
         c = rem[i];
         for (int j = 1; j <= P; j++) rem[i+j] = rem[i+j] ^ gm(c, gpoly[P-j]);
      end
      for (int k = 0; k < P; k++) par[k] = rem[len+k];
   endtask

   task automatic build_exp(input int len, input bit with_par, input bit trunc, input bit err_first);
      rec_t r;
      for (int i = 0; i < len; i++) begin
         r     = '0;
         r.d   = msg[i];
         r.sop = (i == 0);
         r.err = (err_first && i == 0) || (trunc && i == len - 1);
         expq.push_back(r);
      end
      if (with_par) begin
         model(len);
         for (int k = 0; k < P; k++) begin
            r     = '0;
            r.d   = par[k];
            r.par = 1'b1;
            r.eop = (k == P - 1);
            expq.push_back(r);
         end
      end
   endtask

   task automatic send(input int len, input bit with_sop, input bit with_eop);
      int guard;
      for (int i = 0; i < len; i++) begin
         guard = 0;
         @(negedge CLK);
         in_valid = 1'b1;
         in_data  = msg[i];
         in_sop   = with_sop && (i == 0);
         in_eop   = with_eop && (i == len - 1);
         while (!in_ready && guard < 64) begin
            @(negedge CLK);
            guard++;
         end
         if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_ready sym %0d: in_ready=%b after %0d cycles, required 1", i, in_ready, guard);
            return;
         end
         @(posedge CLK);
      end
   endtask

   task automatic idle();
      @(negedge CLK);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic clear_q();
      outq.delete();
      expq.delete();
      cycq.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      total++;
      if ({out_valid, out_data, out_sop, out_eop, out_parity, out_err, in_ready} !== 14'h0001) begin
         bad++;
         $display("FAIL reset_hold: outs=%h, required 0001", {out_valid, out_data, out_sop, out_eop, out_parity, out_err, in_ready});
      end
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_zero();
      for (int i = 0; i < 239; i++) msg[i] = 8'h00;
      clear_q();
      build_exp(239, 1, 0, 0);
      ready_low = 0;
      send(239, 1, 1);
      idle();
      repeat (25) @(negedge CLK);
      total++;
      if (outq.size() != expq.size()) begin
         bad++;
         $display("FAIL zero_len: got %0d symbols, required %0d", outq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL zero_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
      total++;
      if (outq.size() < 255 || outq[254].eop !== 1'b1) begin
         bad++;
         $display("FAIL zero_eop255: size=%0d, required eop on output 255", outq.size());
      end
      total++;
      if (ready_low != P) begin
         bad++;
         $display("FAIL zero_ready_low: got %0d cycles, required %0d", ready_low, P);
      end
   endtask

   task automatic test_single();
      msg[0] = 8'h01;
      clear_q();
      build_exp(1, 1, 0, 0);
      send(1, 1, 1);
      idle();
      repeat (25) @(negedge CLK);
      total++;
      if (outq.size() != 17) begin
         bad++;
         $display("FAIL single_len: got %0d symbols, required 17", outq.size());
      end
      for (int i = 0; i < 17 && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL single_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
      for (int k = 0; k < P && k + 1 < outq.size(); k++) begin
         total++;
         if (outq[k+1].d !== gpoly[P-1-k]) begin
            bad++;
            $display("FAIL single_gcoef[%0d]: got %h, required %h", P - 1 - k, outq[k+1].d, gpoly[P-1-k]);
         end
      end
   endtask

   task automatic test_linearity();
      logic [7:0] a [0:63];
      logic [7:0] b [0:63];
      logic [7:0] pv [0:2][0:P-1];
      logic [7:0] root;
      logic [7:0] s;
      int         len;
      len = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
         a[i] = 8'($urandom);
         b[i] = 8'($urandom);
      end
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < len; i++) msg[i] = (v == 0) ? a[i] : (v == 1) ? b[i] : (a[i] ^ b[i]);
         clear_q();
         build_exp(len, 1, 0, 0);
         send(len, 1, 1);
         idle();
         repeat (25) @(negedge CLK);
         total++;
         if (outq.size() != expq.size()) begin
            bad++;
            $display("FAIL lin%0d_len: got %0d symbols, required %0d", v, outq.size(), expq.size());
         end
         for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            total++;
            if (outq[i] !== expq[i]) begin
               bad++;
               $display("FAIL lin%0d_sym[%0d]: got %h, required %h", v, i, outq[i], expq[i]);
            end
         end
         for (int k = 0; k < P; k++) pv[v][k] = (len + k < outq.size()) ? outq[len+k].d : 8'hxx;
         root = 8'h01;
         for (int i = 0; i < P; i++) begin
            s = 8'h00;
            for (int j = 0; j < outq.size(); j++) s = gm(s, root) ^ outq[j].d;
            total++;
            if (s !== 8'h00) begin
               bad++;
               $display("FAIL lin%0d_syndrome[%0d]: got %h, required 00", v, i, s);
            end
            root = gm(root, 8'h02);
         end
      end
      for (int k = 0; k < P; k++) begin
         total++;
         if (pv[2][k] !== (pv[0][k] ^ pv[1][k])) begin
            bad++;
            $display("FAIL lin_xor[%0d]: got %h, required %h", k, pv[2][k], pv[0][k] ^ pv[1][k]);
         end
      end
   endtask

   task automatic test_no_sop();
      for (int i = 0; i < 5; i++) msg[i] = 8'($urandom);
      clear_q();
      send(5, 0, 1);
      idle();
      repeat (10) @(negedge CLK);
      total++;
      if (outq.size() != 0) begin
         bad++;
         $display("FAIL nosop_output: got %0d symbols, required 0", outq.size());
      end
   endtask

   task automatic test_sop_abort();
      clear_q();
      for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
      build_exp(10, 0, 0, 0);
      send(10, 1, 0);
      for (int i = 0; i < 7; i++) msg[i] = 8'($urandom);
      build_exp(7, 1, 0, 1);
      send(7, 1, 1);
      idle();
      repeat (25) @(negedge CLK);
      total++;
      if (outq.size() != expq.size()) begin
         bad++;
         $display("FAIL abort_len: got %0d symbols, required %0d", outq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL abort_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
   endtask

   task automatic test_truncate();
      for (int i = 0; i < 240; i++) msg[i] = 8'($urandom);
      clear_q();
      build_exp(239, 1, 1, 0);
      send(240, 1, 0);
      idle();
      repeat (25) @(negedge CLK);
      total++;
      if (outq.size() != expq.size()) begin
         bad++;
         $display("FAIL trunc_len: got %0d symbols, required %0d", outq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL trunc_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 8; i++) msg[i] = 8'($urandom);
      clear_q();
      build_exp(8, 1, 0, 0);
      send(8, 1, 1);
      idle();
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      #1 RESET = 1'b1;
      #1;
      total++;
      if ({out_valid, out_data, out_sop, out_eop, out_parity, out_err, in_ready} !== 14'h0001) begin
         bad++;
         $display("FAIL midreset_outs: outs=%h, required 0001", {out_valid, out_data, out_sop, out_eop, out_parity, out_err, in_ready});
      end
      total++;
      if (outq.size() != 13) begin
         bad++;
         $display("FAIL midreset_count: got %0d symbols before reset, required 13", outq.size());
      end
      for (int i = 0; i < 13 && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL midreset_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
      @(negedge CLK);
      RESET = 1'b0;
      repeat (20) @(negedge CLK);
      total++;
      if (outq.size() != 13) begin
         bad++;
         $display("FAIL midreset_silent: got %0d symbols, required 13", outq.size());
      end
      clear_q();
      build_exp(8, 1, 0, 0);
      send(8, 1, 1);
      idle();
      repeat (25) @(negedge CLK);
      total++;
      if (outq.size() != expq.size()) begin
         bad++;
         $display("FAIL midreset_redo_len: got %0d symbols, required %0d", outq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL midreset_redo_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int la;
      int lb;
      la = $urandom_range(5, 30);
      lb = $urandom_range(5, 30);
      clear_q();
      for (int i = 0; i < la; i++) msg[i] = 8'($urandom);
      build_exp(la, 1, 0, 0);
      send(la, 1, 1);
      for (int i = 0; i < lb; i++) msg[i] = 8'($urandom);
      build_exp(lb, 1, 0, 0);
      send(lb, 1, 1);
      idle();
      repeat (40) @(negedge CLK);
      total++;
      if (outq.size() != expq.size()) begin
         bad++;
         $display("FAIL b2b_len: got %0d symbols, required %0d", outq.size(), expq.size());
      end
      for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
         total++;
         if (outq[i] !== expq[i]) begin
            bad++;
            $display("FAIL b2b_sym[%0d]: got %h, required %h", i, outq[i], expq[i]);
         end
      end
      total++;
      if (cycq.size() == 0 || cycq[cycq.size()-1] - cycq[0] != cycq.size() - 1) begin
         bad++;
         $display("FAIL b2b_gapless: span=%0d cycles for %0d symbols, required contiguous",
                  (cycq.size() == 0) ? 0 : cycq[cycq.size()-1] - cycq[0] + 1, cycq.size());
      end
   endtask

   initial begin
      make_gen();
      test_reset();
      test_zero();
      test_single();
      test_linearity();
      test_no_sop();
      test_sop_abort();
      test_truncate();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
